// File: rtl/output_buffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// output_buffer_write_arbiter
//
// Shares the single write port of the output buffer among NUM_REQ write
// requesters (one per PE write-buffer controller). Requests are arbitrated
// round-robin only while the buffer reports ready. The winner's word is
// registered onto the buffer port together with a one-cycle write strobe and
// grant. Completed writes are counted up to TOTAL_WRITES, after which done is
// raised until start is withdrawn.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        level, enables arbitration for one run
//   req          per-requester write request, held until granted
//   req_data     requester words, word i on [i*DATA_W +: DATA_W]
//   buf_ready    output buffer can accept a write
//   grant        one-hot single-cycle acknowledge to the winner
//   stall        requester i is waiting (req[i] & ~grant[i]), combinational
//   buf_wr_en    write strobe to the output buffer
//   buf_wr_data  registered winner data
//   write_count  writes completed in the current run
//   done         run complete
// -----------------------------------------------------------------------------
module output_buffer_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 16,
    parameter int TOTAL_WRITES = 16,
    parameter int CNT_W        = $clog2(TOTAL_WRITES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      buf_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        stall,
    output logic                      buf_wr_en,
    output logic [DATA_W-1:0]         buf_wr_data,
    output logic [CNT_W-1:0]          write_count,
    output logic                      done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // First requester with req set, scanning upward from ptr_v and wrapping.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req_v,
        input logic [PTR_W-1:0]   ptr_v
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = {PTR_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_v) + k) % NUM_REQ;
            if (!found && req_v[PTR_W'(idx)]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;

    logic [PTR_W-1:0]    pick_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [PTR_W-1:0]    ptr_next_s;

    assign pick_s     = rr_pick(req, ptr_q);
    assign cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // Pointer moves just past the winner; explicit wrap keeps non power-of-two counts correct.
    assign ptr_next_s = (win_q == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                       : win_q + {{(PTR_W-1){1'b0}}, 1'b1};

    // Next-state and registered-output computation for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = {NUM_REQ{1'b0}};
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARB;
                    cnt_d   = {CNT_W{1'b0}};
                    ptr_d   = {PTR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (buf_ready && (|req)) begin
                    // Strobe and grant are registered here so they appear during WRITE.
                    state_d = ST_WRITE;
                    win_d   = pick_s;
                    data_d  = req_data[int'(pick_s) * DATA_W +: DATA_W];
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                    wr_en_d = 1'b1;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_WRITE: begin
                // The write always completes; start and buf_ready are ignored here.
                ptr_d = ptr_next_s;
                cnt_d = cnt_inc_s;
                if (cnt_inc_s == CNT_W'(TOTAL_WRITES)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {PTR_W{1'b0}};
            win_q   <= {PTR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            grant_q <= {NUM_REQ{1'b0}};
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
        end
    end

    assign stall       = req & ~grant_q;
    assign grant       = grant_q;
    assign buf_wr_en   = wr_en_q;
    assign buf_wr_data = data_q;
    assign write_count = cnt_q;
    assign done        = done_q;

endmodule
